// File: rtl/ycocg2rgb_pipe.sv
// Two-stage YCoCg-R to RGB inverse lifting pipeline with valid/ready handshakes,
// optional per-depth clamping, and per-line / clip counters.
module ycocg2rgb_pipe #(
  parameter bit CLIP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         bpc_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [13:0] in_y,
  input  logic signed [13:0] in_co,
  input  logic signed [13:0] in_cg,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [11:0]        out_r,
  output logic [11:0]        out_g,
  output logic [11:0]        out_b,
  output logic               out_last,
  output logic [15:0]        clip_cnt,
  output logic [15:0]        pix_cnt
);

  typedef struct packed {
    logic        clip;
    logic [11:0] val;
  } comp_t;

  // Clamp a 15-bit signed component to [0, max_v]; flags whether it was clamped.
  function automatic comp_t clamp_comp(input logic signed [14:0] v,
                                       input logic [11:0]        max_v);
    comp_t c;
    c.clip = 1'b0;
    c.val  = v[11:0];
    if (CLIP_EN) begin
      if (v < 15'sd0) begin
        c.clip = 1'b1;
        c.val  = 12'd0;
      end else if (v > $signed({3'b000, max_v})) begin
        c.clip = 1'b1;
        c.val  = max_v;
      end
    end
    return c;
  endfunction

  // Stage 1 state
  logic               s1_valid_q, s1_valid_d;
  logic signed [14:0] s1_t_q,  s1_t_d;
  logic signed [14:0] s1_g_q,  s1_g_d;
  logic signed [14:0] s1_co_q, s1_co_d;
  logic               s1_last_q, s1_last_d;

  // Stage 2 (output) state
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_r_q, out_r_d;
  logic [11:0] out_g_q, out_g_d;
  logic [11:0] out_b_q, out_b_d;
  logic        out_last_q, out_last_d;
  logic        out_clip_q, out_clip_d;

  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic [15:0] pix_cnt_q,  pix_cnt_d;

  logic               adv2, adv1, in_hs, out_hs;
  logic signed [14:0] y_x, co_x, cg_x, t_x, g_x;
  logic signed [14:0] b_x, r_x;
  logic [11:0]        max_v;
  comp_t              r_c, g_c, b_c;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign in_hs    = in_valid && adv1;
  assign out_hs   = out_valid_q && out_ready;

  // First lifting half: recover t and g from the incoming sample.
  assign y_x  = {in_y[13],  in_y};
  assign co_x = {in_co[13], in_co};
  assign cg_x = {in_cg[13], in_cg};
  assign t_x  = y_x - (cg_x >>> 1);
  assign g_x  = cg_x + t_x;

  // Second lifting half: recover b and r from the stage-1 registers.
  assign b_x = s1_t_q - (s1_co_q >>> 1);
  assign r_x = b_x + s1_co_q;

  always_comb begin
    case (bpc_sel)
      2'd0:    max_v = 12'h0FF;
      2'd1:    max_v = 12'h3FF;
      default: max_v = 12'hFFF;
    endcase
  end

  assign r_c = clamp_comp(r_x,    max_v);
  assign g_c = clamp_comp(s1_g_q, max_v);
  assign b_c = clamp_comp(b_x,    max_v);

  // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latch).
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_t_d      = s1_t_q;
    s1_g_d      = s1_g_q;
    s1_co_d     = s1_co_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_g_d     = out_g_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
    out_clip_d  = out_clip_q;
    clip_cnt_d  = clip_cnt_q;
    pix_cnt_d   = pix_cnt_q;

    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_hs) begin
        s1_t_d    = t_x;
        s1_g_d    = g_x;
        s1_co_d   = co_x;
        s1_last_d = in_last;
      end
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_r_d    = r_c.val;
        out_g_d    = g_c.val;
        out_b_d    = b_c.val;
        out_last_d = s1_last_q;
        out_clip_d = r_c.clip || g_c.clip || b_c.clip;
      end
    end

    if (out_hs) begin
      pix_cnt_d = out_last_q ? 16'd0 : pix_cnt_q + 16'd1;
      if (out_clip_q && (clip_cnt_q != 16'hFFFF)) begin
        clip_cnt_d = clip_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  // NOTE: datapath registers are reset too so outputs read as zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_t_q      <= '0;
      s1_g_q      <= '0;
      s1_co_q     <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
      out_clip_q  <= 1'b0;
      clip_cnt_q  <= '0;
      pix_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_t_q      <= s1_t_d;
      s1_g_q      <= s1_g_d;
      s1_co_q     <= s1_co_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
      out_clip_q  <= out_clip_d;
      clip_cnt_q  <= clip_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_g     = out_g_q;
  assign out_b     = out_b_q;
  assign out_last  = out_last_q;
  assign clip_cnt  = clip_cnt_q;
  assign pix_cnt   = pix_cnt_q;

endmodule
